// File: rtl/tqvp_scroll_compositor_pkg.sv
// Shared constants for the scroll compositor: register map, CTRL bit positions,
// colour width and the byte-lane helpers used by every register block.
package tqvp_scroll_compositor_pkg;

  localparam logic [5:0] ADDR_CTRL        = 6'h00;
  localparam logic [5:0] ADDR_STATUS      = 6'h04;
  localparam logic [5:0] ADDR_IRQ_PERIOD  = 6'h08;
  localparam logic [5:0] ADDR_KEY         = 6'h0C;
  localparam logic [5:0] ADDR_BACKDROP    = 6'h10;
  localparam logic [5:0] ADDR_SCROLL_BASE = 6'h20;
  localparam logic [5:0] ADDR_SPEED_BASE  = 6'h24;
  localparam int         LAYER_STRIDE     = 8;

  localparam int CTRL_ENABLE_BIT   = 0;
  localparam int CTRL_LAYER_EN_LSB = 1;
  localparam int CTRL_IRQ_EN_BIT   = 8;

  localparam int COLOUR_W = 6;
  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'b00,
    ACC_HALF = 2'b01,
    ACC_WORD = 2'b10,
    ACC_NONE = 2'b11
  } access_t;

  function automatic logic [3:0] byte_enables(input logic [1:0] write_n);
    case (access_t'(write_n))
      ACC_BYTE: return 4'b0001;
      ACC_HALF: return 4'b0011;
      ACC_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/tqvp_scroll_compositor_scroll_layer_unit.sv
// One background layer: SCROLL/SPEED registers with byte-lane writes, the
// per-frame auto-scroll step and the scrolled-coordinate adders.
module scroll_layer_unit
  import tqvp_scroll_compositor_pkg::*;
#(
  parameter int SCROLL_W = 10,
  parameter int COORD_W  = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scroll_sel_i,
  input  logic                speed_sel_i,
  input  logic [3:0]          byte_en_i,
  input  logic [31:0]         wdata_i,
  input  logic                tick_i,
  input  logic [COORD_W-1:0]  pix_x_i,
  input  logic [COORD_W-1:0]  pix_y_i,
  output logic [SCROLL_W-1:0] layer_x_o,
  output logic [SCROLL_W-1:0] layer_y_o,
  output logic [31:0]         scroll_rdata_o,
  output logic [31:0]         speed_rdata_o
);

  logic [SCROLL_W-1:0] scroll_x_q, scroll_y_q, scroll_x_d, scroll_y_d;
  logic [7:0]          dx_q, dy_q;
  logic [31:0]         wmask, scroll_merged, speed_merged;
  logic                unused_bits;

  assign wmask          = expand_mask(byte_en_i);
  assign scroll_rdata_o = 32'(scroll_x_q) | (32'(scroll_y_q) << 16);
  assign speed_rdata_o  = {16'd0, dy_q, dx_q};
  // Merge against the read view so untouched byte lanes keep their value.
  assign scroll_merged  = (scroll_rdata_o & ~wmask) | (wdata_i & wmask);
  assign speed_merged   = (speed_rdata_o & ~wmask) | (wdata_i & wmask);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    if (scroll_sel_i) begin
      scroll_x_d = scroll_merged[SCROLL_W-1:0];
      scroll_y_d = scroll_merged[16+:SCROLL_W];
    end else if (tick_i) begin
      scroll_x_d = scroll_x_q + SCROLL_W'($signed(dx_q));
      scroll_y_d = scroll_y_q + SCROLL_W'($signed(dy_q));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scroll_x_q <= '0;
      scroll_y_q <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
    end else begin
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
      if (speed_sel_i) begin
        dx_q <= speed_merged[7:0];
        dy_q <= speed_merged[15:8];
      end
    end
  end

  assign layer_x_o = SCROLL_W'(pix_x_i) + scroll_x_q;
  assign layer_y_o = SCROLL_W'(pix_y_i) + scroll_y_q;

  assign unused_bits = ^{scroll_merged, speed_merged[31:16], pix_x_i, pix_y_i};

endmodule

// File: rtl/tqvp_scroll_compositor.sv
// TinyQV peripheral compositing scrolling background layers onto RGB222 VGA:
// global registers, frame tick, interrupt divider and priority compositor.
module tqvp_scroll_compositor
  import tqvp_scroll_compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int SCROLL_W   = 10,
  parameter int COORD_W    = 11
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [5:0]                     address,
  input  logic [31:0]                    data_in,
  input  logic [1:0]                     data_write_n,
  input  logic [1:0]                     data_read_n,
  output logic [31:0]                    data_out,
  output logic                           data_ready,
  input  logic [COORD_W-1:0]             pix_x,
  input  logic [COORD_W-1:0]             pix_y,
  input  logic                           visible,
  input  logic                           hsync_in,
  input  logic                           vsync_in,
  input  logic [COLOUR_W*NUM_LAYERS-1:0] layer_rgb,
  output logic [SCROLL_W*NUM_LAYERS-1:0] layer_x,
  output logic [SCROLL_W*NUM_LAYERS-1:0] layer_y,
  output logic [7:0]                     uo_out,
  output logic                           user_interrupt
);

  logic [3:0]            byte_en;
  logic                  wr;
  logic                  enable_q, irq_en_q, irq_pending_q, irq_pending_d, vsync_q;
  logic [NUM_LAYERS-1:0] layer_en_q, scroll_sel, speed_sel;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [7:0]            div_q, div_d, irq_period_q;
  colour_t               key_q, backdrop_q, colour_d;
  logic [7:0]            uo_q, uo_d;
  logic                  tick, advance, irq_set;
  logic [31:0]           scroll_rdata [NUM_LAYERS];
  logic [31:0]           speed_rdata  [NUM_LAYERS];
  logic                  unused_read_n;

  assign byte_en = byte_enables(data_write_n);
  assign wr      = |byte_en;
  assign tick    = vsync_in & ~vsync_q;
  assign advance = tick & enable_q;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    assign scroll_sel[i] = wr && (address == ADDR_SCROLL_BASE + 6'(LAYER_STRIDE * i));
    assign speed_sel[i]  = wr && (address == ADDR_SPEED_BASE + 6'(LAYER_STRIDE * i));

    scroll_layer_unit #(
      .SCROLL_W (SCROLL_W),
      .COORD_W  (COORD_W)
    ) u_layer (
      .clk            (clk),
      .rst_n          (rst_n),
      .scroll_sel_i   (scroll_sel[i]),
      .speed_sel_i    (speed_sel[i]),
      .byte_en_i      (byte_en),
      .wdata_i        (data_in),
      .tick_i         (advance),
      .pix_x_i        (pix_x),
      .pix_y_i        (pix_y),
      .layer_x_o      (layer_x[SCROLL_W*i+:SCROLL_W]),
      .layer_y_o      (layer_y[SCROLL_W*i+:SCROLL_W]),
      .scroll_rdata_o (scroll_rdata[i]),
      .speed_rdata_o  (speed_rdata[i])
    );
  end

  // A fresh interrupt beats a same-cycle W1C so no period is ever lost.
  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    div_d         = div_q;
    irq_pending_d = irq_pending_q;
    irq_set       = 1'b0;
    if (advance) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      if (div_q == irq_period_q) begin
        div_d   = '0;
        irq_set = irq_en_q;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
    if (wr && address == ADDR_IRQ_PERIOD) div_d = '0;
    if (wr && address == ADDR_STATUS && data_in[0]) irq_pending_d = 1'b0;
    if (irq_set) irq_pending_d = 1'b1;
  end

  // Scan from the highest index down so the lowest enabled, non-key layer wins.
  always_comb begin
    colour_d = backdrop_q;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_en_q[i] && layer_rgb[COLOUR_W*i+:COLOUR_W] != key_q)
        colour_d = layer_rgb[COLOUR_W*i+:COLOUR_W];
    end
    if (!visible || !enable_q) colour_d = '0;
  end

  assign uo_d = {vsync_in, hsync_in, colour_d};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable_q      <= 1'b0;
      layer_en_q    <= '0;
      irq_en_q      <= 1'b0;
      irq_pending_q <= 1'b0;
      frame_cnt_q   <= '0;
      div_q         <= '0;
      irq_period_q  <= '0;
      key_q         <= '0;
      backdrop_q    <= '0;
      vsync_q       <= 1'b0;
      uo_q          <= '0;
    end else begin
      vsync_q       <= vsync_in;
      uo_q          <= uo_d;
      frame_cnt_q   <= frame_cnt_d;
      div_q         <= div_d;
      irq_pending_q <= irq_pending_d;
      if (wr) begin
        case (address)
          ADDR_CTRL: begin
            enable_q   <= data_in[CTRL_ENABLE_BIT];
            layer_en_q <= data_in[CTRL_LAYER_EN_LSB+:NUM_LAYERS];
            if (byte_en[1]) irq_en_q <= data_in[CTRL_IRQ_EN_BIT];
          end
          ADDR_IRQ_PERIOD: irq_period_q <= data_in[7:0];
          ADDR_KEY:        key_q        <= data_in[COLOUR_W-1:0];
          ADDR_BACKDROP:   backdrop_q   <= data_in[COLOUR_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL: begin
        data_out[CTRL_ENABLE_BIT]                  = enable_q;
        data_out[CTRL_LAYER_EN_LSB+:NUM_LAYERS]    = layer_en_q;
        data_out[CTRL_IRQ_EN_BIT]                  = irq_en_q;
      end
      ADDR_STATUS: begin
        data_out[0]     = irq_pending_q;
        data_out[31:16] = frame_cnt_q;
      end
      ADDR_IRQ_PERIOD: data_out[7:0]          = irq_period_q;
      ADDR_KEY:        data_out[COLOUR_W-1:0] = key_q;
      ADDR_BACKDROP:   data_out[COLOUR_W-1:0] = backdrop_q;
      default: ;
    endcase
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (address == ADDR_SCROLL_BASE + 6'(LAYER_STRIDE * i)) data_out = scroll_rdata[i];
      if (address == ADDR_SPEED_BASE + 6'(LAYER_STRIDE * i))  data_out = speed_rdata[i];
    end
  end

  assign uo_out         = uo_q;
  assign user_interrupt = irq_pending_q;
  assign data_ready     = 1'b1;
  assign unused_read_n  = ^data_read_n;

endmodule
